// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S definitions: rx FSM state encoding and channel select constants.
package i2s_pkg;
    typedef enum logic [1:0] {RX_SYNC, RX_LEFT, RX_RIGHT} rx_state_e;
    localparam logic I2S_CH_LEFT  = 1'b0;
    localparam logic I2S_CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_edge_det.sv
// i2s_edge_det: 2-flop sampler with rise detect on edge_i, plus matched 2-flop delay of lvl_i.
module i2s_edge_det #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         edge_i,
    input  logic [W-1:0] lvl_i,
    output logic         rise_o,
    output logic [W-1:0] lvl_o
);
    logic         e1_q, e2_q;
    logic [W-1:0] l1_q, l2_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e1_q <= 1'b0;
            e2_q <= 1'b0;
            l1_q <= '0;
            l2_q <= '0;
        end else begin
            e1_q <= edge_i;
            e2_q <= e1_q;
            l1_q <= lvl_i;
            l2_q <= l1_q;
        end
    end
    assign rise_o = e1_q & ~e2_q;
    assign lvl_o  = l2_q;
endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S receive deserializer, serial stream to left/right pairs over valid/ready.
// Define I2S_RX_OVERRUN_EN to add the sticky overrun_out flag.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH = 32
) (
    input  logic                   mclk_in,
    input  logic                   rst_in,
    input  logic                   lrck_in,
    input  logic                   sclk_in,
    input  logic                   sdata_in,
    input  logic                   pready_in,
`ifdef I2S_RX_OVERRUN_EN
    output logic                   overrun_out,
`endif
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   pvalid_out
);
    localparam int CW = $clog2(PDATA_WIDTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(PDATA_WIDTH);
    logic                   rise, lr, sd;
    rx_state_e              state_q, state_d;
    logic                   lr_prev_q, lr_prev_d;
    logic [CW-1:0]          cnt_q, cnt_d, pos;
    logic [PDATA_WIDTH-1:0] sh_q, sh_d, word;
    logic [PDATA_WIDTH-1:0] lhold_q, lhold_d, rhold_q, rhold_d;
    logic [PDATA_WIDTH-1:0] pl_q, pl_d, pr_q, pr_d;
    logic                   done_q, done_d, pv_q, pv_d;
`ifdef I2S_RX_OVERRUN_EN
    logic                   ovr_q, ovr_d;
`endif
    i2s_edge_det #(.W(2)) u_sclk (
        .clk_i  (mclk_in),
        .rst_i  (rst_in),
        .edge_i (sclk_in),
        .lvl_i  ({lrck_in, sdata_in}),
        .rise_o (rise),
        .lvl_o  ({lr, sd})
    );
    // Current bit merged into the word so the final bit is included when latching.
    assign pos  = CW'(PDATA_WIDTH - 1) - cnt_q;
    assign word = (cnt_q < CMAX) ? (sh_q | (PDATA_WIDTH'(sd) << pos)) : sh_q;
    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        lhold_d   = lhold_q;
        rhold_d   = rhold_q;
        done_d    = 1'b0;
        pl_d      = pl_q;
        pr_d      = pr_q;
        pv_d      = pv_q;
`ifdef I2S_RX_OVERRUN_EN
        ovr_d     = ovr_q | (done_q & pv_q & ~pready_in);
`endif
        if (rise) begin
            lr_prev_d = lr;
            if (lr != lr_prev_q) begin
                cnt_d = '0;
                sh_d  = '0;
                if (state_q == RX_SYNC) begin
                    state_d = (lr == I2S_CH_LEFT) ? RX_LEFT : RX_SYNC;
                end else if (state_q == RX_LEFT) begin
                    lhold_d = word;
                    state_d = RX_RIGHT;
                end else begin
                    rhold_d = word;
                    done_d  = 1'b1;
                    state_d = RX_LEFT;
                end
            end else if (state_q != RX_SYNC) begin
                sh_d  = word;
                cnt_d = (cnt_q < CMAX) ? cnt_q + CW'(1) : cnt_q;
            end
        end
        if (done_q) begin
            pl_d = lhold_q;
            pr_d = rhold_q;
            pv_d = 1'b1;
        end else if (pv_q && pready_in) begin
            pv_d = 1'b0;
        end
    end
    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            state_q   <= RX_SYNC;
            lr_prev_q <= 1'b0;
            cnt_q     <= '0;
            sh_q      <= '0;
            lhold_q   <= '0;
            rhold_q   <= '0;
            done_q    <= 1'b0;
            pl_q      <= '0;
            pr_q      <= '0;
            pv_q      <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
            ovr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            lhold_q   <= lhold_d;
            rhold_q   <= rhold_d;
            done_q    <= done_d;
            pl_q      <= pl_d;
            pr_q      <= pr_d;
            pv_q      <= pv_d;
`ifdef I2S_RX_OVERRUN_EN
            ovr_q     <= ovr_d;
`endif
        end
    end
    assign pldata_out = pl_q;
    assign prdata_out = pr_q;
    assign pvalid_out = pv_q;
`ifdef I2S_RX_OVERRUN_EN
    assign overrun_out = ovr_q;
`endif
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed I2S stream (4 mclk per sclk) with hand-computed expected frames.
module tb_i2s_rx_deser;
    logic        mclk = 1'b0, rst = 1'b1, lrck = 1'b0, sclk = 1'b0, sdata = 1'b0, pready = 1'b1;
    logic [31:0] pl, pr;
    logic        pv, pend = 1'b0;
`ifdef I2S_RX_OVERRUN_EN
    logic        ovr;
`endif
    int          checks = 0, errors = 0, hi_cnt = 0;
    logic [63:0] got_q[$], exp_q[$];

    i2s_rx_deser #(.PDATA_WIDTH(32)) dut (
        .mclk_in    (mclk),
        .rst_in     (rst),
        .lrck_in    (lrck),
        .sclk_in    (sclk),
        .sdata_in   (sdata),
        .pready_in  (pready),
`ifdef I2S_RX_OVERRUN_EN
        .overrun_out(ovr),
`endif
        .pldata_out (pl),
        .prdata_out (pr),
        .pvalid_out (pv)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (pv) hi_cnt++;
        if (pv && pready) got_q.push_back({pl, pr});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        sclk = 1'b0; lrck = lr; sdata = d;
        repeat (2) @(posedge mclk);
        #1 sclk = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
    endtask

    // period 0 carries the previous word's last bit (one-bit delay); w is MSB-aligned at bit 63
    task automatic chan(input logic lr, input logic [63:0] w, input int s, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (i == 0) send_bit(lr, pend);
            else        send_bit(lr, w[64 - i]);
        end
        if (hi == s) pend = w[64 - s];
    endtask

    task automatic frame(input logic [63:0] l, input logic [63:0] r, input int s);
        chan(1'b0, l, s, 0, s);
        chan(1'b1, r, s, 0, s);
    endtask

    initial begin
        @(posedge mclk); #1;
        chan(1'b0, {32'hDEAD_0000, 32'h0}, 32, 0, 12);
        chk("rst_pv", {63'h0, pv}, 64'h0);
        chk("rst_pl", {32'h0, pl}, 64'h0);
        chk("rst_pr", {32'h0, pr}, 64'h0);
        rst = 1'b0;
        chan(1'b0, {32'hDEAD_0000, 32'h0}, 32, 12, 32);
        chan(1'b1, {32'hBEEF_0000, 32'h0}, 32, 0, 32);
        frame({32'hA5A5_0001, 32'h0}, {32'h8000_00FF, 32'h0}, 32);
        exp_q.push_back({32'hA5A5_0001, 32'h8000_00FF});
        frame({32'h5555_AAAA, 32'h0}, {32'h0F0F_0F0F, 32'h0}, 32);
        exp_q.push_back({32'h5555_AAAA, 32'h0F0F_0F0F});
        chk("pulses", 64'(hi_cnt), 64'd1);
        pready = 1'b0;
        fork
            frame({32'h1357_9BDF, 32'h0}, {32'h2468_ACE0, 32'h0}, 32);
            begin
                for (int k = 0; k < 2000 && !pv; k++) @(negedge mclk);
                chk("bp_seen", {63'h0, pv}, 64'h1);
                repeat (3) begin
                    @(negedge mclk);
                    chk("bp_hold_pv", {63'h0, pv}, 64'h1);
                    chk("bp_hold_data", {pl, pr}, {32'h5555_AAAA, 32'h0F0F_0F0F});
                end
                @(posedge mclk); #1 pready = 1'b1;
                @(negedge mclk);
                @(negedge mclk);
                chk("bp_clear", {63'h0, pv}, 64'h0);
            end
        join
        exp_q.push_back({32'h1357_9BDF, 32'h2468_ACE0});
        frame({32'h1234_5600, 32'h0}, {32'hABCD_EF00, 32'h0}, 32);
        exp_q.push_back({32'h1234_5600, 32'hABCD_EF00});
        frame({24'h123456, 40'h0}, {24'hFEDCBA, 40'h0}, 24);
        exp_q.push_back({32'h1234_5600, 32'hFEDC_BA00});
        frame({40'hDE_ADBE_EF12, 24'h0}, {40'h01_2345_6789, 24'h0}, 40);
        exp_q.push_back({32'hDEAD_BEEF, 32'h0123_4567});
        frame({32'h89AB_CDEF, 32'h0}, {32'h7654_3210, 32'h0}, 32);
        pready = 1'b0;
        frame({32'h1111_1111, 32'h0}, {32'h2222_2222, 32'h0}, 32);
        frame({32'h3333_3333, 32'h0}, {32'h4444_4444, 32'h0}, 32);
        frame({32'h5555_5555, 32'h0}, {32'h6666_6666, 32'h0}, 32);
        @(negedge mclk);
        chk("ovr_pv", {63'h0, pv}, 64'h1);
        chk("ovr_data", {pl, pr}, {32'h3333_3333, 32'h4444_4444});
`ifdef I2S_RX_OVERRUN_EN
        chk("ovr_flag", {63'h0, ovr}, 64'h1);
`endif
        @(posedge mclk); #1 pready = 1'b1;
        exp_q.push_back({32'h3333_3333, 32'h4444_4444});
        exp_q.push_back({32'h5555_5555, 32'h6666_6666});
        chan(1'b0, {32'h7777_7777, 32'h0}, 32, 0, 32);
`ifdef I2S_RX_OVERRUN_EN
        chk("ovr_sticky", {63'h0, ovr}, 64'h1);
`endif
        chan(1'b1, {32'h8888_8888, 32'h0}, 32, 0, 10);
        rst = 1'b1;
        @(posedge mclk); #1 rst = 1'b0;
        @(negedge mclk);
        chk("mid_rst_pv", {63'h0, pv}, 64'h0);
        chk("mid_rst_data", {pl, pr}, 64'h0);
`ifdef I2S_RX_OVERRUN_EN
        chk("mid_rst_ovr", {63'h0, ovr}, 64'h0);
`endif
        @(posedge mclk); #1;
        chan(1'b1, {32'h8888_8888, 32'h0}, 32, 10, 32);
        frame({32'h0BAD_F00D, 32'h0}, {32'hFEED_FACE, 32'h0}, 32);
        exp_q.push_back({32'h0BAD_F00D, 32'hFEED_FACE});
        chan(1'b0, {32'h0, 32'h0}, 32, 0, 32);
        chk("nframes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("frame%0d", i), got_q[i], exp_q[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
